// File: rtl/output_drain_scheduler.sv
// Output drain scheduler: buffers finished convolution outputs, throttles the controller with stall,
// drains over valid/ready and tracks layer completion. Optional macro: OUTPUT_DRAIN_COORDS_EN (per-entry x/y/ch storage).
module output_drain_scheduler #(
  parameter int DATA_WIDTH         = 32,
  parameter int LOG2_FIFO_DEPTH    = 2,
  parameter int ALMOST_FULL_MARGIN = 1,
  parameter int TOTAL_OUTPUTS      = 16
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [31:0]                in_x,
  input  logic [31:0]                in_y,
  input  logic [31:0]                in_ch,
  output logic                       stall,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [31:0]                out_x,
  output logic [31:0]                out_y,
  output logic [31:0]                out_ch,
  output logic                       out_last,
  output logic                       done,
  output logic [LOG2_FIFO_DEPTH:0]   count,
  output logic                       overflow,
  output logic [1:0]                 state_dbg
);

  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam int PW    = LOG2_FIFO_DEPTH;
  localparam int CW    = LOG2_FIFO_DEPTH + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [31:0]   LAST_IDX = 32'(TOTAL_OUTPUTS - 1);

  // Encoding is visible on state_dbg: 0 = IDLE, 1 = ACTIVE, 2 = DONE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [31:0] drained_q, drained_d;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic push, pop, drop;

  // Handshake: the input side is a non-stallable strobe (in_valid, no ready); an entry is
  // accepted if there is room or the head leaves in the same cycle, otherwise it is dropped
  // and overflow latches. The output side transfers on out_valid && out_ready, and the head
  // stays stable while out_valid is high and out_ready is low.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && ((count < DEPTH_C) || pop);
  assign drop = in_valid && !push;

  assign out_valid = (count != '0);
  assign stall     = (count >= STALL_TH);
  assign out_data  = data_mem[rd_ptr];
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef OUTPUT_DRAIN_COORDS_EN
  logic [31:0] x_mem  [DEPTH];
  logic [31:0] y_mem  [DEPTH];
  logic [31:0] ch_mem [DEPTH];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        x_mem[i]  <= '0;
        y_mem[i]  <= '0;
        ch_mem[i] <= '0;
      end
    end else if (push) begin
      x_mem[wr_ptr]  <= in_x;
      y_mem[wr_ptr]  <= in_y;
      ch_mem[wr_ptr] <= in_ch;
    end
  end

  assign out_x  = x_mem[rd_ptr];
  assign out_y  = y_mem[rd_ptr];
  assign out_ch = ch_mem[rd_ptr];
`else
  logic unused_coords;
  assign unused_coords = ^{in_x, in_y, in_ch};

  assign out_x  = '0;
  assign out_y  = '0;
  assign out_ch = '0;
`endif

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q   <= S_IDLE;
      drained_q <= '0;
    end else begin
      state_q   <= state_d;
      drained_q <= drained_d;
    end
  end

  // drained only counts pops of the layer being tracked; pops outside ACTIVE are free traffic.
  always_comb begin
    state_d   = state_q;
    drained_d = drained_q;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACTIVE;
          drained_d = '0;
        end
      end
      S_ACTIVE: begin
        out_last = out_valid && (drained_q == LAST_IDX);
        if (pop) begin
          drained_d = drained_q + 32'd1;
          if (out_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_output_drain_scheduler.sv
// Bench for output_drain_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_output_drain_scheduler;

  localparam int DW    = 32;
  localparam int L2D   = 2;
  localparam int DEPTH = 1 << L2D;
  localparam int MARG  = 1;
  localparam int TOTAL = 16;
  localparam int EW    = DW + 96;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [31:0] in_x = '0, in_y = '0, in_ch = '0;
  logic out_ready = 1'b0;
  logic stall, out_valid, out_last, done, overflow;
  logic [DW-1:0] out_data;
  logic [31:0] out_x, out_y, out_ch;
  logic [L2D:0] count;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  output_drain_scheduler #(
    .DATA_WIDTH(DW), .LOG2_FIFO_DEPTH(L2D),
    .ALMOST_FULL_MARGIN(MARG), .TOTAL_OUTPUTS(TOTAL)
  ) dut (
    .clk(clk), .arst_n_in(arst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .out_last(out_last), .done(done), .count(count), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

`ifdef OUTPUT_DRAIN_COORDS_EN
  localparam bit COORDS = 1'b1;
`else
  localparam bit COORDS = 1'b0;
`endif

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of entries, sticky overflow flag, layer tracking by pop count.
  logic [EW-1:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_active = 1'b0;
  bit m_done = 1'b0;
  int m_drained = 0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_active = 1'b0;
      m_done = 1'b0;
      m_drained = 0;
    end else begin
      bit pop_m;
      bit push_m;
      logic [EW-1:0] ent;
      pop_m  = (exp_q.size() != 0) && out_ready;
      push_m = in_valid && ((exp_q.size() < DEPTH) || pop_m);
      if (in_valid && !push_m) m_ovf = 1'b1;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_drained = 0;
        end
      end else if (pop_m) begin
        if (m_drained == TOTAL - 1) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end else begin
          m_drained++;
        end
      end
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) begin
        ent = COORDS ? {in_data, in_x, in_y, in_ch} : {in_data, 96'd0};
        exp_q.push_back(ent);
      end
    end
  end

  // Scoreboard compare on the falling edge, plus handshake / last / done recording.
  logic [DW-1:0] got_q[$];
  int last_cnt = 0;
  int done_cnt = 0;
  logic [DW-1:0] last_data = '0;

  always @(negedge clk) begin
    if (arst_n) begin
      bit exp_valid;
      exp_valid = (exp_q.size() != 0);
      check("out_valid", EW'(out_valid), EW'(exp_valid));
      check("count", EW'(count), EW'(exp_q.size()));
      check("stall", EW'(stall), EW'(exp_q.size() >= DEPTH - MARG));
      check("overflow", EW'(overflow), EW'(m_ovf));
      check("out_last", EW'(out_last), EW'(m_active && exp_valid && (m_drained == TOTAL - 1)));
      check("done", EW'(done), EW'(m_done));
      check("state", EW'(state_dbg), EW'(m_done ? 2 : (m_active ? 1 : 0)));
      if (exp_valid) check("head", {out_data, out_x, out_y, out_ch}, exp_q[0]);
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (out_last) begin
        last_cnt++;
        last_data = out_data;
      end
      if (done) done_cnt++;
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ch, input logic rdy,
                       input logic st);
    in_valid = v; in_data = d; in_x = x; in_y = y; in_ch = ch;
    out_ready = rdy; start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    // Reset values
    #1 arst_n = 1'b0;
    #1;
    check("rst_count", EW'(count), EW'(0));
    check("rst_valid", EW'(out_valid), EW'(0));
    check("rst_stall", EW'(stall), EW'(0));
    check("rst_ovf", EW'(overflow), EW'(0));
    check("rst_done", EW'(done), EW'(0));
    check("rst_last", EW'(out_last), EW'(0));
    check("rst_data", {out_data, out_x, out_y, out_ch}, EW'(0));
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single entry
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h11, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    check("single_valid", EW'(out_valid), EW'(1));
    check("single_count", EW'(count), EW'(1));
    check("single_data", EW'(out_data), EW'(32'h11));
    check("single_coords", {out_x, out_y, out_ch},
          COORDS ? {32'd1, 32'd2, 32'd3} : 96'd0);
    idle(1'b1);
    check("single_drain", EW'(count), EW'(0));
    check("single_empty", EW'(out_valid), EW'(0));

    // Fill and stall
    do_reset();
    drive(1'b1, 32'hA1, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 0, 0, 0, 1'b0, 1'b0);
    check("fill2_stall", EW'(stall), EW'(0));
    drive(1'b1, 32'hA3, 0, 0, 0, 1'b0, 1'b0);
    check("fill3_count", EW'(count), EW'(3));
    check("fill3_stall", EW'(stall), EW'(1));
    drive(1'b1, 32'hA4, 0, 0, 0, 1'b0, 1'b0);
    check("fill4_count", EW'(count), EW'(4));
    check("fill4_ovf", EW'(overflow), EW'(0));
    drive(1'b1, 32'hA5, 0, 0, 0, 1'b0, 1'b0);
    check("drop_count", EW'(count), EW'(4));
    check("drop_ovf", EW'(overflow), EW'(1));
    check("drop_head", EW'(out_data), EW'(32'hA1));
    idle(1'b0);

    // Full with simultaneous push and pop, order across wrap
    do_reset();
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h500 + i, i, i, i, 1'b0, 1'b0);
    check("full_count", EW'(count), EW'(4));
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h504 + k, k, k, k, 1'b1, 1'b0);
      check("pp_count", EW'(count), EW'(4));
      check("pp_ovf", EW'(overflow), EW'(0));
      check("pp_head", EW'(out_data), EW'(32'h501 + k));
    end
    for (int k = 0; k < 4; k++) idle(1'b1);
    check("wrap_empty", EW'(count), EW'(0));
    check("wrap_n", EW'(got_q.size()), EW'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("wrap_order", EW'(got_q[i]), EW'(32'h500 + i));

    // Backpressure hold
    do_reset();
    got_q.delete();
    for (int i = 0; i < 20; i++)
      drive(i < 8, 32'h200 + i, i, i + 1, i + 2, 1'(i % 2), 1'b0);
    check("bp_count", EW'(count), EW'(0));
    check("bp_ovf", EW'(overflow), EW'(0));
    check("bp_n", EW'(got_q.size()), EW'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_order", EW'(got_q[i]), EW'(32'h200 + i));

    // Layer completion, twice
    do_reset();
    last_cnt = 0;
    done_cnt = 0;
    drive(1'b0, '0, 0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h300 + i, i, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("layer1_last_n", EW'(last_cnt), EW'(1));
    check("layer1_last_data", EW'(last_data), EW'(32'h30F));
    check("layer1_done_n", EW'(done_cnt), EW'(1));
    check("layer1_idle", EW'(state_dbg), EW'(0));
    drive(1'b0, '0, 0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h400 + i, i, 0, 0, 1'b1, i == 5);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("layer2_last_n", EW'(last_cnt), EW'(2));
    check("layer2_last_data", EW'(last_data), EW'(32'h40F));
    check("layer2_done_n", EW'(done_cnt), EW'(2));

    // Reset mid-run
    do_reset();
    drive(1'b0, '0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h600 + i, 0, 0, 0, 1'b0, 1'b0);
    check("mid_ovf_set", EW'(overflow), EW'(1));
    idle(1'b1);
    idle(1'b1);
    check("mid_count2", EW'(count), EW'(2));
    idle(1'b0);
    #2 arst_n = 1'b0;
    #1;
    check("mid_valid", EW'(out_valid), EW'(0));
    check("mid_count", EW'(count), EW'(0));
    check("mid_stall", EW'(stall), EW'(0));
    check("mid_ovf", EW'(overflow), EW'(0));
    check("mid_state", EW'(state_dbg), EW'(0));
    check("mid_data", EW'(out_data), EW'(0));
    @(posedge clk);
    #1 arst_n = 1'b1;
    last_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 18; i++) drive(i < 16, 32'h700 + i, 0, 0, 0, 1'b1, 1'b0);
    check("nostart_last", EW'(last_cnt), EW'(0));
    check("nostart_done", EW'(done_cnt), EW'(0));
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_drain_scheduler.md
# output_drain_scheduler

Buffers finished convolution outputs (accumulator value plus x/y/ch coordinates) between the accelerator controller and the host output link. It sits downstream of the controller's registered `output_valid` pulse, which cannot be back-pressured. Instead it throttles the controller with `stall` before its FIFO can overflow. It drains entries over a valid/ready handshake, marks the last output of a layer, and pulses `done` when the layer has fully left the chip.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one output value.
- `LOG2_FIFO_DEPTH`, 2: FIFO depth is 2**`LOG2_FIFO_DEPTH`; must be ≥1.
- `ALMOST_FULL_MARGIN`, 1: free slots reserved when `stall` rises; 1 ≤ margin < depth.
- `TOTAL_OUTPUTS`, 16: outputs per layer (W*H*OUTPUT_NB_CHANNELS); ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `arst_n_in` in 1: reset, asynchronous, active-low.
- `start` in 1: begin tracking a layer (honoured in IDLE only).
- `in_valid` in 1: one-cycle push strobe from controller.
- `in_data` in `DATA_WIDTH`: output value.
- `in_x`, `in_y`, `in_ch` in 32 each: output coordinates.
- `stall` out 1: controller must not start a new MAC while high.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: host accepts head entry.
- `out_data` out `DATA_WIDTH`, `out_x`/`out_y`/`out_ch` out 32 each: head entry.
- `out_last` out 1: head entry is the layer's final output.
- `done` out 1: one-cycle pulse after the final handshake.
- `count` out `LOG2_FIFO_DEPTH`+1: current occupancy.
- `overflow` out 1: sticky, set when a push is dropped.

## Operation
- Storage is a circular register array with `wr_ptr` and `rd_ptr` of `LOG2_FIFO_DEPTH` bits each. Pointers wrap naturally. `count` is tracked separately.
- **Push:**
  - Accepted when `in_valid` && (`count` < depth || pop in the same cycle).
  - When accepted, the entry is written at `wr_ptr` and `wr_ptr` increments.
  - A push while full with no pop is dropped. It sets `overflow` (cleared only by reset). `count` and contents are unchanged.
- **Pop:** occurs when `out_valid` && `out_ready`. `rd_ptr` increments.
- **Count:** `count` changes by +1 on push only, −1 on pop only, and is unchanged when both happen in the same cycle.
- **Head outputs:** `out_valid` = (`count` != 0). `out_data`/`out_x`/`out_y`/`out_ch` are a combinational read of the array at `rd_ptr`. The head entry is stable while `out_valid` && !`out_ready`.
- **Stall:** `stall` = (`count` ≥ depth − `ALMOST_FULL_MARGIN`), combinational from `count`.
- **State machine (IDLE, ACTIVE, DONE):**
  - IDLE: `start` → ACTIVE; the 32-bit `drained` counter is cleared to 0.
  - ACTIVE:
    - Each pop increments `drained`.
    - `out_last` = `out_valid` && (`drained` == `TOTAL_OUTPUTS`−1).
    - A pop with `out_last` high → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
  - `start` in ACTIVE or DONE is ignored.
  - Pushes and pops work in every state. Pops in IDLE/DONE do not increment `drained`, and `out_last` is 0 outside ACTIVE.

## Timing
- **Reset values:** `stall`=0, `out_valid`=0, `out_last`=0, `done`=0, `count`=0, `overflow`=0. `out_data`/`out_x`/`out_y`/`out_ch`=0 (array cleared), state=IDLE, pointers=0, `drained`=0.
- **Latency:** push at edge N makes the entry visible with `out_valid` high after edge N. There is no same-cycle bypass.
- **Stall:** rises in the cycle after the push that reaches the threshold. The margin absorbs the controller's one in-flight registered `output_valid`.
- **Full + simultaneous push/pop:** both are accepted, `count` stays at depth, and `overflow` stays 0.
- **Empty + `out_ready`:** no pop and no pointer change.
- **Reset mid-operation:** contents are discarded immediately (async), all outputs return to their reset values, and the state returns to IDLE.
- **`done`:** asserted in the cycle after the final pop.

## Configuration
- `OUTPUT_DRAIN_COORDS_EN`:
  - Defined: `in_x`/`in_y`/`in_ch` are stored per entry and presented on `out_x`/`out_y`/`out_ch`.
  - Undefined: coordinate storage is removed, `out_x`/`out_y`/`out_ch` are tied to 0, and the coordinate inputs are ignored.
  - Data, handshake, stall and layer tracking are identical in both builds.

## Test plan
- **Single entry:** reset, `start`, push `in_data`=0x11, x=1, y=2, ch=3 with `out_ready`=1 → `out_valid` the next cycle with 0x11/1/2/3 (0/0/0 with the macro undefined). `count` goes 1→0.
- **Fill and stall** (DEPTH=4, MARGIN=1, `out_ready`=0): push 3 entries → `stall`=1 once `count`=3. A 4th push → `count`=4, `overflow`=0. A 5th push → dropped, `overflow`=1, head still holds the 1st entry.
- **Full with simultaneous push and pop:** full FIFO, `in_valid`=1 and `out_ready`=1 together → `count` stays 4, `overflow`=0. Output order is preserved across pointer wrap (pushes 0..7 emerge as 0..7).
- **Backpressure hold:** `out_ready` toggles 0/1 every cycle → head values are stable while not ready and no entry is lost or duplicated.
- **Layer completion** (`TOTAL_OUTPUTS`=16): 16 pushes and pops in ACTIVE → `out_last` high only with the 16th head, `done` pulses one cycle later, state returns to IDLE. A second `start` restarts `drained` from 0.
- **Reset mid-run:** assert `arst_n_in` low with `count`=2 in ACTIVE → `out_valid`=0, `count`=0, `stall`=0 and `overflow`=0 immediately. After release, a `start` is required before `out_last` can assert.
